// File: rtl/buffer_arb_pkg.sv
// Shared types and helpers for the buffer write-port arbiter and its round-robin picker.
package buffer_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // Cyclic increment of a round-robin pointer over n slots.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    if (ptr >= n - 32'd1) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational cyclic first-one finder: returns the first set bit of req at or after
// start, wrapping from N-1 back to 0.
module rr_picker
  import buffer_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [IDW:0] sum_s;
  logic [IDW:0] wrap_s;

  // Scan from the farthest offset down so the nearest hit is the one that sticks.
  always_comb begin
    found  = |req;
    idx    = '0;
    sum_s  = '0;
    wrap_s = '0;
    for (int off = N - 1; off >= 0; off--) begin
      sum_s  = {1'b0, start} + (IDW + 1)'(off);
      wrap_s = (sum_s >= (IDW + 1)'(N)) ? (sum_s - (IDW + 1)'(N)) : sum_s;
      idx    = req[wrap_s[IDW-1:0]] ? wrap_s[IDW-1:0] : idx;
    end
  end

endmodule

// File: rtl/buffer_wr_arbiter.sv
// Round-robin arbiter with bounded bursts that shares one buffer write port among
// NUM_REQ producers; the owner keeps the port for at most MAX_BURST accepted writes.
module buffer_wr_arbiter
  import buffer_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       buf_full,
  output logic                       buf_write_en,
  output logic [WIDTH-1:0]           buf_data_in,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]  burst_cnt_q, burst_cnt_d;
  logic           grant_valid_q, grant_valid_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;

  logic           pick_found_s;
  logic [IDW-1:0] pick_idx_s;
  logic           owned_s;
  logic           owner_valid_s;
  logic           accept_s;
  logic           last_beat_s;
  logic [IDW-1:0] next_ptr_s;

  rr_picker #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_picker (
    .req   (req_valid),
    .start (rr_ptr_q),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Write-side datapath is combinational from registered ownership so async reset clears it at once.
  always_comb begin
    owned_s       = (state_q == ARB_OWNED);
    owner_valid_s = req_valid[grant_id_q];
    accept_s      = owned_s && owner_valid_s && !buf_full;
    last_beat_s   = (burst_cnt_q == BW'(MAX_BURST - 1));
    next_ptr_s    = IDW'(rr_next(32'(grant_id_q), 32'(NUM_REQ)));
    buf_write_en  = accept_s;
    if (owned_s && !buf_full) begin
      req_ready = {{(NUM_REQ - 1){1'b0}}, 1'b1} << grant_id_q;
    end else begin
      req_ready = '0;
    end
    if (owned_s) begin
      buf_data_in = req_data[int'(grant_id_q) * WIDTH +: WIDTH];
    end else begin
      buf_data_in = '0;
    end
  end

  // Next-state logic: grant from IDLE, then hold, count, or release while OWNED.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    burst_cnt_d   = burst_cnt_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found_s) begin
          state_d       = ARB_OWNED;
          grant_valid_d = 1'b1;
          grant_id_d    = pick_idx_s;
          burst_cnt_d   = '0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_OWNED: begin
        if ((accept_s && last_beat_s) || (!owner_valid_s && !buf_full)) begin
          state_d       = ARB_IDLE;
          rr_ptr_d      = next_ptr_s;
          burst_cnt_d   = '0;
          grant_valid_d = 1'b0;
          grant_id_d    = '0;
        end else if (accept_s) begin
          burst_cnt_d = burst_cnt_q + BW'(1'b1);
        end else begin
          state_d = ARB_OWNED;
        end
      end
      default: begin
        state_d       = ARB_IDLE;
        rr_ptr_d      = '0;
        burst_cnt_d   = '0;
        grant_valid_d = 1'b0;
        grant_id_d    = '0;
      end
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      rr_ptr_q      <= '0;
      burst_cnt_q   <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      burst_cnt_q   <= burst_cnt_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_buffer_wr_arbiter.sv
// Directed bench for buffer_wr_arbiter: a 4-producer/burst-4 instance and a
// 3-producer/burst-1 instance driven from one linear stimulus sequence.
module tb_buffer_wr_arbiter;

  logic        clk;
  logic        rst_n;

  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        buf_full;
  logic        buf_write_en;
  logic [15:0] buf_data_in;
  logic        grant_valid;
  logic [1:0]  grant_id;

  logic [2:0]  req_valid1;
  logic [47:0] req_data1;
  logic [2:0]  req_ready1;
  logic        buf_full1;
  logic        buf_write_en1;
  logic [15:0] buf_data_in1;
  logic        grant_valid1;
  logic [1:0]  grant_id1;

  int checks;
  int passes;
  int fails;

  buffer_wr_arbiter #(.NUM_REQ(4), .WIDTH(16), .MAX_BURST(4)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .buf_full     (buf_full),
    .buf_write_en (buf_write_en),
    .buf_data_in  (buf_data_in),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  buffer_wr_arbiter #(.NUM_REQ(3), .WIDTH(16), .MAX_BURST(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid1),
    .req_data     (req_data1),
    .req_ready    (req_ready1),
    .buf_full     (buf_full1),
    .buf_write_en (buf_write_en1),
    .buf_data_in  (buf_data_in1),
    .grant_valid  (grant_valid1),
    .grant_id     (grant_id1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst_n      = 1'b0;
    req_valid  = 4'h0;
    buf_full   = 1'b0;
    req_valid1 = 3'b000;
    buf_full1  = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic chk_owned(input string tag, input logic [1:0] g);
    chk({tag, "_gv"},   32'(grant_valid),  32'd1);
    chk({tag, "_gid"},  32'(grant_id),     32'(g));
    chk({tag, "_rdy"},  32'(req_ready),    32'(4'b0001 << g));
    chk({tag, "_we"},   32'(buf_write_en), 32'd1);
    chk({tag, "_data"}, 32'(buf_data_in),  32'h0000_A000 + 32'(g));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gv"},   32'(grant_valid),  32'd0);
    chk({tag, "_gid"},  32'(grant_id),     32'd0);
    chk({tag, "_rdy"},  32'(req_ready),    32'd0);
    chk({tag, "_we"},   32'(buf_write_en), 32'd0);
    chk({tag, "_data"}, 32'(buf_data_in),  32'd0);
  endtask

  initial begin
    checks     = 0;
    passes     = 0;
    fails      = 0;
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_data   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    buf_full   = 1'b0;
    req_valid1 = 3'b000;
    req_data1  = {16'hA012, 16'hA011, 16'hA010};
    buf_full1  = 1'b0;

    // Reset with every producer requesting.
    cyc();
    cyc();
    #1;
    chk_idle("rst");
    rst_n = 1'b1;

    // Round-robin 0,1,2,3,0 with four writes each and one idle cycle between grants.
    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < 4; w++) begin
        cyc();
        #1;
        chk_owned($sformatf("rr_g%0d_w%0d", k, w), 2'(k % 4));
      end
      cyc();
      #1;
      chk_idle($sformatf("rr_gap%0d", k));
    end

    // Early release: producer 2 valid for two writes only, then producer 1 requests.
    do_reset();
    req_valid = 4'b0100;
    cyc();
    #1;
    chk_owned("er_w0", 2'd2);
    cyc();
    #1;
    chk_owned("er_w1", 2'd2);
    cyc();
    req_valid = 4'b0010;
    #1;
    chk("er_drop_we",  32'(buf_write_en), 32'd0);
    chk("er_drop_gid", 32'(grant_id),     32'd2);
    chk("er_drop_rdy", 32'(req_ready),    32'h4);
    cyc();
    #1;
    chk_idle("er_rel");
    cyc();
    #1;
    chk_owned("er_next", 2'd1);

    // Full stall after two writes: held for five cycles, then exactly two more writes.
    do_reset();
    req_valid = 4'b0001;
    cyc();
    #1;
    chk_owned("fs_w0", 2'd0);
    cyc();
    #1;
    chk_owned("fs_w1", 2'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      buf_full = 1'b1;
      #1;
      chk($sformatf("fs_stall%0d_we", i),  32'(buf_write_en), 32'd0);
      chk($sformatf("fs_stall%0d_rdy", i), 32'(req_ready),    32'd0);
      chk($sformatf("fs_stall%0d_gv", i),  32'(grant_valid),  32'd1);
      chk($sformatf("fs_stall%0d_gid", i), 32'(grant_id),     32'd0);
    end
    cyc();
    buf_full = 1'b0;
    #1;
    chk_owned("fs_w2", 2'd0);
    cyc();
    #1;
    chk_owned("fs_w3", 2'd0);
    cyc();
    #1;
    chk_idle("fs_rel");

    // Async reset in the middle of producer 1's burst, with rr_ptr already advanced.
    do_reset();
    req_valid = 4'hF;
    for (int w = 0; w < 4; w++) begin
      cyc();
    end
    cyc();
    cyc();
    #1;
    chk_owned("ar_pre", 2'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle("ar_async");
    cyc();
    rst_n = 1'b1;
    cyc();
    #1;
    chk_owned("ar_post", 2'd0);

    // MAX_BURST=1 instance: producers 0 and 2 alternate, one write every two cycles.
    do_reset();
    req_valid1 = 3'b101;
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      chk($sformatf("mb1_%0d_gv", k),   32'(grant_valid1),  32'd1);
      chk($sformatf("mb1_%0d_gid", k),  32'(grant_id1),     (k % 2 == 1) ? 32'd2 : 32'd0);
      chk($sformatf("mb1_%0d_rdy", k),  32'(req_ready1),    (k % 2 == 1) ? 32'h4 : 32'h1);
      chk($sformatf("mb1_%0d_we", k),   32'(buf_write_en1), 32'd1);
      chk($sformatf("mb1_%0d_data", k), 32'(buf_data_in1),  (k % 2 == 1) ? 32'hA012 : 32'hA010);
      cyc();
      #1;
      chk($sformatf("mb1_gap%0d_gv", k),  32'(grant_valid1),  32'd0);
      chk($sformatf("mb1_gap%0d_we", k),  32'(buf_write_en1), 32'd0);
      chk($sformatf("mb1_gap%0d_rdy", k), 32'(req_ready1),    32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
